uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop line synchronizer, oversampled bit-centre sampling,
// 5..8 data bits, optional even/odd parity, 1 or 2 stop bits, registered RTS.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [14:0] clock_divider_i,
  input  logic [1:0]  data_bits_i,
  input  logic        stop_bits_i,
  input  logic        parity_enable_i,
  input  logic        parity_mode_i,
  input  logic        flow_control_i,
  input  logic        fifo_full_i,
  input  logic        rx_i,
  output logic        rts_n_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        parity_error_o,
  output logic        frame_error_o,
  output logic        busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t        state, state_nx;
  logic          rx_s1, rx_s2;
  logic [14:0]   div_cnt, div_r;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_r;
  logic          par_acc, par_err, frm_err;
  logic [1:0]    dbits_r;
  logic          stop2_r, par_en_r, par_odd_r;
  logic          armed;
  logic          tick, sample, last_data, last_stop, start;

  // A start needs the line to have been seen high in IDLE (or at the end of
  // the previous frame), so a held-low break line cannot retrigger frames.
  assign start     = (state == IDLE) && enable_i && armed && !rx_s2;
  assign tick      = (state != IDLE) && (div_cnt == div_r);
  assign sample    = tick && (tick_cnt == ((state == START) ? HALF : FULL));
  assign last_data = (bit_cnt == {1'b1, dbits_r});
  assign last_stop = (bit_cnt == {2'b00, stop2_r});
  assign valid_o   = (state == DONE);
  assign busy_o    = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state; losing enable aborts any frame without a strobe
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = START;
      START:   if (sample) state_nx = rx_s2 ? IDLE : DATA;
      DATA:    if (sample && last_data) state_nx = par_en_r ? PARITY : STOP;
      PARITY:  if (sample) state_nx = STOP;
      STOP:    if (sample && last_stop) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!enable_i) state_nx = IDLE;
  end

  // Line synchronizer and start-arming flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      armed <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      case (state)
        IDLE:    armed <= start ? 1'b0 : (armed | rx_s2);
        DONE:    armed <= rx_s2;
        default: armed <= 1'b0;
      endcase
    end
  end

  // Frame datapath: config capture, tick/bit counters, shift and error tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      div_r     <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_r   <= '0;
      par_acc   <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      dbits_r   <= '0;
      stop2_r   <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
    end else if (start) begin
      div_r     <= clock_divider_i;
      dbits_r   <= data_bits_i;
      stop2_r   <= stop_bits_i;
      par_en_r  <= parity_enable_i;
      par_odd_r <= parity_mode_i;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_r   <= '0;
      par_acc   <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else if (state != IDLE) begin
      div_cnt <= tick ? '0 : div_cnt + 15'd1;
      if (tick) tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
      if (sample) begin
        case (state)
          DATA: begin
            shift_r[bit_cnt] <= rx_s2;
            par_acc          <= par_acc ^ rx_s2;
            bit_cnt          <= last_data ? 3'd0 : bit_cnt + 3'd1;
          end
          PARITY: if (rx_s2 != (par_acc ^ par_odd_r)) par_err <= 1'b1;
          STOP: begin
            if (!rx_s2) frm_err <= 1'b1;
            bit_cnt <= last_stop ? 3'd0 : bit_cnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Result registers load on entry to DONE and hold until the next frame;
  // the final stop sample is folded in directly since frm_err lags it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o         <= 8'h00;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
    end else if (state == STOP && state_nx == DONE) begin
      data_o         <= shift_r;
      parity_error_o <= par_err;
      frame_error_o  <= frm_err | !rx_s2;
    end
  end

  // Registered request-to-send
  always_ff @(posedge clk_i) begin
    if (rst_i) rts_n_o <= 1'b1;
    else       rts_n_o <= !(flow_control_i && enable_i && !fifo_full_i);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: directed corner frames plus randomized frames checked
// against a frame-level reference model (masking, parity rule, stop rule).
module tb_uart_receiver;
  localparam int OS = 16;

  logic        clk_i = 0, rst_i = 1, enable_i = 1;
  logic [14:0] clock_divider_i = '0;
  logic [1:0]  data_bits_i = 2'd3;
  logic        stop_bits_i = 0, parity_enable_i = 0, parity_mode_i = 0;
  logic        flow_control_i = 1, fifo_full_i = 0, rx_i = 1;
  logic        rts_n_o, valid_o, parity_error_o, frame_error_o, busy_o;
  logic [7:0]  data_o;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .clock_divider_i(clock_divider_i), .data_bits_i(data_bits_i),
    .stop_bits_i(stop_bits_i), .parity_enable_i(parity_enable_i),
    .parity_mode_i(parity_mode_i), .flow_control_i(flow_control_i),
    .fifo_full_i(fifo_full_i), .rx_i(rx_i), .rts_n_o(rts_n_o),
    .data_o(data_o), .valid_o(valid_o), .parity_error_o(parity_error_o),
    .frame_error_o(frame_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  int n_cmp = 0, n_err = 0;

  typedef struct { logic [7:0] d; logic pe; logic fe; int unsigned cyc; } rx_t;
  rx_t obs_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // capture every strobe cycle; a stretched strobe shows up as extra entries
  always @(negedge clk_i) begin
    rx_t r;
    if (valid_o) begin
      r.d = data_o; r.pe = parity_error_o; r.fe = frame_error_o; r.cyc = cyc;
      obs_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // serialize one frame; t0 is the cycle the start bit appears on rx_i
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                            input int nstop, input bit s0, input bit s1, output int unsigned t0);
    int p;
    p = (int'(clock_divider_i) + 1) * OS;
    @(posedge clk_i); #1;
    t0 = cyc;
    rx_i = 1'b0; hold(p);
    for (int i = 0; i < nb; i++) begin rx_i = d[i]; hold(p); end
    if (pen) begin rx_i = pbit; hold(p); end
    rx_i = s0; hold(p);
    if (nstop == 2) begin rx_i = s1; hold(p); end
    rx_i = 1'b1; hold(2 * p);
  endtask

  // configure, send, and compare the single strobe against the model
  task automatic run_frame(input string tag, input logic [7:0] d, input int nb, input bit pen,
                           input bit odd, input bit pbit, input int nstop, input bit s0, input bit s1);
    int unsigned t0;
    logic [7:0] mask, exp_d;
    bit exp_pe, exp_fe;
    int p, total, dt;
    rx_t r;
    data_bits_i = 2'(nb - 5);
    parity_enable_i = pen;
    parity_mode_i = odd;
    stop_bits_i = (nstop == 2);
    obs_q.delete();
    send_frame(d, nb, pen, pbit, nstop, s0, s1, t0);
    mask   = 8'((1 << nb) - 1);
    exp_d  = d & mask;
    exp_pe = pen && (pbit != ((^exp_d) ^ odd));
    exp_fe = !s0 || (nstop == 2 && !s1);
    p      = (int'(clock_divider_i) + 1) * OS;
    total  = 1 + nb + (pen ? 1 : 0) + nstop;
    chk({tag, ".cnt"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() >= 1) begin
      r  = obs_q.pop_front();
      dt = int'(r.cyc - t0);
      chk({tag, ".data"}, {24'd0, r.d}, {24'd0, exp_d});
      chk({tag, ".pe"}, {31'd0, r.pe}, {31'd0, exp_pe});
      chk({tag, ".fe"}, {31'd0, r.fe}, {31'd0, exp_fe});
      // strobe must land in the second half of the last stop bit
      chk({tag, ".when"}, {31'd0, (dt >= (total - 1) * p + p / 2) && (dt <= total * p)}, 32'd1);
    end
  endtask

  initial begin
    int unsigned t0;
    bit pen, odd, pbit, s0, s1;
    int nb, ns;
    logic [7:0] d;

    // reset state
    hold(3);
    chk("rst.data", {24'd0, data_o}, 32'd0);
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.pe", {31'd0, parity_error_o}, 32'd0);
    chk("rst.fe", {31'd0, frame_error_o}, 32'd0);
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.rts", {31'd0, rts_n_o}, 32'd1);
    rst_i = 0;
    hold(4);

    // 8N1, divider 0
    run_frame("a5", 8'hA5, 8, 0, 0, 0, 1, 1, 1);

    // 7 bits even parity, both parity bit values
    run_frame("p35_0", 8'h35, 7, 1, 0, 0, 1, 1, 1);
    run_frame("p35_1", 8'h35, 7, 1, 0, 1, 1, 1, 1);

    // 5 bits, two stop bits, second one low
    run_frame("s2lo", 8'h1F, 5, 0, 0, 0, 2, 1, 0);

    // short glitch on an idle line
    obs_q.delete();
    @(posedge clk_i); #1;
    rx_i = 0; hold(4);
    chk("glitch.busy_hi", {31'd0, busy_o}, 32'd1);
    rx_i = 1; hold(16);
    chk("glitch.busy_lo", {31'd0, busy_o}, 32'd0);
    chk("glitch.novalid", 32'(obs_q.size()), 32'd0);

    // drop enable in the middle of the data bits
    data_bits_i = 2'd3; parity_enable_i = 0; stop_bits_i = 0;
    @(posedge clk_i); #1;
    rx_i = 0; hold(OS);
    rx_i = 0; hold(OS);
    rx_i = 0; hold(OS);
    rx_i = 1; hold(OS / 2);
    chk("en.busy_hi", {31'd0, busy_o}, 32'd1);
    enable_i = 0; hold(1);
    chk("en.busy_lo", {31'd0, busy_o}, 32'd0);
    hold(5 * OS);
    enable_i = 1; hold(2 * OS);
    chk("en.novalid", 32'(obs_q.size()), 32'd0);
    run_frame("en3c", 8'h3C, 8, 0, 0, 0, 1, 1, 1);

    // RTS follows fifo_full one cycle later
    flow_control_i = 1; fifo_full_i = 0; hold(2);
    chk("rts.lo", {31'd0, rts_n_o}, 32'd0);
    fifo_full_i = 1;
    chk("rts.lag1", {31'd0, rts_n_o}, 32'd0);
    hold(1);
    chk("rts.hi", {31'd0, rts_n_o}, 32'd1);
    fifo_full_i = 0;
    chk("rts.lag0", {31'd0, rts_n_o}, 32'd1);
    hold(1);
    chk("rts.lo2", {31'd0, rts_n_o}, 32'd0);
    flow_control_i = 0; hold(1);
    chk("rts.noflow", {31'd0, rts_n_o}, 32'd1);

    // divider 3
    clock_divider_i = 15'd3;
    run_frame("d3_81", 8'h81, 8, 0, 0, 0, 1, 1, 1);

    // reset in the middle of a frame
    obs_q.delete();
    @(posedge clk_i); #1;
    rx_i = 0; hold(3 * 4 * OS);
    rst_i = 1; hold(1);
    chk("mrst.busy", {31'd0, busy_o}, 32'd0);
    chk("mrst.data", {24'd0, data_o}, 32'd0);
    rst_i = 0; rx_i = 1; hold(4 * 4 * OS);
    chk("mrst.novalid", 32'(obs_q.size()), 32'd0);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      clock_divider_i = 15'($urandom_range(0, 3));
      nb   = $urandom_range(5, 8);
      pen  = $urandom_range(0, 1) != 0;
      odd  = $urandom_range(0, 1) != 0;
      ns   = $urandom_range(1, 2);
      d    = 8'($urandom);
      pbit = ((^(d & 8'((1 << nb) - 1))) ^ odd) ^ ($urandom_range(0, 3) == 0);
      s0   = $urandom_range(0, 4) != 0;
      s1   = $urandom_range(0, 4) != 0;
      run_frame($sformatf("rnd%0d", k), d, nb, pen, odd, pbit, ns, s0, s1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
